// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types and helpers for the round-robin logging-unit stream arbiter
// and its picker.
package rr_stream_arbiter_pkg;

    typedef enum logic {
        RR_STREAM_ARB_IDLE = 1'b0,
        RR_STREAM_ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int DEFAULT_NUM_SRC = 4;

    typedef logic [$clog2(DEFAULT_NUM_SRC)-1:0] src_idx_t;

    // Width needed to express a bit count of 0..full_width inclusive.
    function automatic int offset_width(input int full_width);
        return $clog2(full_width + 1);
    endfunction

    function automatic int src_idx_width(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/rr_stream_arbiter_picker.sv
// Combinational round-robin picker: grants the first requester at or after ptr,
// wrapping from NUM_SRC-1 back to 0. Shared with the replay-side schedulers.
module rr_rr_picker
    import rr_stream_arbiter_pkg::*;
#(
    parameter int  NUM_SRC = 4,
    localparam int IDX_W   = src_idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] idx;

    // Walk from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_SRC);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter with per-source burst lock feeding one registered output stage.
// Optional statistics counters are enabled by defining RR_STREAM_ARB_STATS_EN.
module rr_stream_arbiter
    import rr_stream_arbiter_pkg::*;
#(
    parameter int  NUM_SRC      = 4,
    parameter int  FULL_WIDTH   = 512,
    parameter int  MAX_BURST    = 8,
    localparam int OFFSET_WIDTH = offset_width(FULL_WIDTH),
    localparam int IDX_W        = src_idx_width(NUM_SRC)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SRC-1:0]              src_valid,
    input  logic [NUM_SRC*FULL_WIDTH-1:0]   src_data,
    input  logic [NUM_SRC*OFFSET_WIDTH-1:0] src_len,
    output logic [NUM_SRC-1:0]              src_ready,
    input  logic                            halt,
    output logic                            out_valid,
    output logic [FULL_WIDTH-1:0]           out_data,
    output logic [OFFSET_WIDTH-1:0]         out_len,
    output logic [IDX_W-1:0]                out_src,
    input  logic                            out_ready,
    output logic                            len_err,
`ifdef RR_STREAM_ARB_STATS_EN
    output logic [NUM_SRC*32-1:0]           stat_units,
    output logic [31:0]                     stat_stall,
`endif
    output logic                            idle
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e         state, state_n;
    logic [IDX_W-1:0]   cur, cur_n, ptr, ptr_n;
    logic [IDX_W-1:0]   pick_ptr, pick_idx, grant_idx;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_n, new_cnt;
    logic [NUM_SRC-1:0] pick_grant, lock_grant, grant;
    logic               lock_hold, ld, xfer;
    logic [FULL_WIDTH-1:0]   sel_data;
    logic [OFFSET_WIDTH-1:0] sel_len;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_SRC - 1) ? '0 : i + 1'b1;
    endfunction

    assign ld = ~out_valid | out_ready;

    // While locked, re-arbitration starts just past the current owner so a
    // source that dropped valid hands over without a bubble.
    assign pick_ptr = (state == RR_STREAM_ARB_LOCK) ? next_idx(cur) : ptr;

    rr_rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
        .req       (src_valid),
        .ptr       (pick_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    // NOTE: every signal driven from always_comb gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        lock_hold          = (state == RR_STREAM_ARB_LOCK) && src_valid[cur];
        lock_grant         = '0;
        lock_grant[cur]    = 1'b1;
        grant              = lock_hold ? lock_grant : pick_grant;
        grant_idx          = lock_hold ? cur : pick_idx;
        src_ready          = (ld && !halt) ? grant : '0;
        xfer               = |src_ready;
    end

    assign sel_data = src_data[int'(grant_idx)*FULL_WIDTH +: FULL_WIDTH];
    assign sel_len  = src_len[int'(grant_idx)*OFFSET_WIDTH +: OFFSET_WIDTH];

    always_comb begin
        state_n     = state;
        cur_n       = cur;
        ptr_n       = ptr;
        burst_cnt_n = burst_cnt;
        new_cnt     = lock_hold ? burst_cnt + 1'b1 : CNT_W'(1);
        if (xfer) begin
            if (state == RR_STREAM_ARB_LOCK && !lock_hold) begin
                ptr_n = pick_ptr;
            end
            if (new_cnt == CNT_W'(MAX_BURST)) begin
                state_n     = RR_STREAM_ARB_IDLE;
                ptr_n       = next_idx(grant_idx);
                burst_cnt_n = '0;
            end else begin
                state_n     = RR_STREAM_ARB_LOCK;
                cur_n       = grant_idx;
                burst_cnt_n = new_cnt;
            end
        end else if (ld && !halt && state == RR_STREAM_ARB_LOCK) begin
            state_n     = RR_STREAM_ARB_IDLE;
            ptr_n       = pick_ptr;
            burst_cnt_n = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RR_STREAM_ARB_IDLE;
            cur       <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            ptr       <= ptr_n;
            burst_cnt <= burst_cnt_n;
        end
    end

    // NOTE: the wide data register is reset too; the consumer may inspect
    // out_data after reset, so it must come up as zero rather than X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
            out_src   <= '0;
            len_err   <= 1'b0;
        end else begin
            if (ld) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= sel_data;
                    out_len  <= sel_len;
                    out_src  <= grant_idx;
                end
            end
            if (xfer && sel_len > OFFSET_WIDTH'(FULL_WIDTH)) begin
                len_err <= 1'b1;
            end
        end
    end

    assign idle = (state == RR_STREAM_ARB_IDLE) && !out_valid;

`ifdef RR_STREAM_ARB_STATS_EN
    logic [31:0] unit_cnt [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_stat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                unit_cnt[g] <= '0;
            end else if (src_valid[g] && src_ready[g] && unit_cnt[g] != '1) begin
                unit_cnt[g] <= unit_cnt[g] + 1'b1;
            end
        end
        assign stat_units[g*32 +: 32] = unit_cnt[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall <= '0;
        end else if (out_valid && !out_ready && stat_stall != '1) begin
            stat_stall <= stat_stall + 1'b1;
        end
    end
`endif

endmodule
